// File: rtl/ddr_init_seq.sv
// DDR SDRAM power-up init sequencer with a post-init refresh-interval timer.
// Command state and registered outputs are both updated from the same
// next-state decode, so the bus reflects the state entered at each edge.
module ddr_init_seq #(
  parameter int          WAIT_POWERUP     = 10000,
  parameter int          T_RP             = 2,
  parameter int          T_MRD            = 2,
  parameter int          T_RFC            = 4,
  parameter int          DLL_WAIT         = 200,
  parameter int          REFRESH_INTERVAL = 390,
  parameter logic [12:0] MODE_REG         = 13'h021,
  parameter logic [12:0] EXT_MODE_REG     = 13'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddr_clk_ok,
  output logic        cke,
  output logic        cs_n,
  output logic [2:0]  cmd,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        done,
  output logic        refresh_req,
  input  logic        refresh_ack,
  output logic        refresh_overrun
);

  localparam logic [3:0] S_WAIT = 4'd0,  S_CKE  = 4'd1,  S_PRE1 = 4'd2,
                         S_EMR  = 4'd3,  S_MRD  = 4'd4,  S_PRE2 = 4'd5,
                         S_REF1 = 4'd6,  S_REF2 = 4'd7,  S_MR   = 4'd8,
                         S_DLLW = 4'd9,  S_DONE = 4'd10;

  localparam logic [2:0] C_NOP = 3'b111, C_PRE = 3'b010,
                         C_REF = 3'b001, C_LMR = 3'b000;

  localparam int GAP_MAX = (T_RP > T_MRD) ? ((T_RP > T_RFC) ? T_RP : T_RFC)
                                          : ((T_MRD > T_RFC) ? T_MRD : T_RFC);
  // Gap counter is loaded with gap-1, so clog2(max gap) bits suffice.
  localparam int GAP_W  = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam int WAIT_W = (WAIT_POWERUP > 0) ? $clog2(WAIT_POWERUP + 1) : 1;
  localparam int DLL_W  = (DLL_WAIT > 0) ? $clog2(DLL_WAIT + 1) : 1;
  localparam int RI_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [3:0]        r_state;
  logic              r_issue;      // 1 during the single command cycle of a state
  logic [GAP_W-1:0]  r_gap;
  logic [WAIT_W-1:0] r_wait;
  logic [DLL_W-1:0]  r_dll;        // cycles elapsed since the DLL-reset MRS (saturating)
  logic [RI_W-1:0]   r_tmr;
  logic              r_cke, r_cs_n, r_done, r_req, r_ovr;
  logic [2:0]        r_cmd;
  logic [1:0]        r_ba;
  logic [12:0]       r_addr;

  logic [3:0]        w_nstate;
  logic              w_nissue;
  logic [GAP_W-1:0]  w_ngap;
  logic [WAIT_W-1:0] w_nwait;
  logic              w_dll_met, w_wrap;
  logic              w_cke, w_done;
  logic [2:0]        w_cmd;
  logic [1:0]        w_ba;
  logic [12:0]       w_addr;

  function automatic int gap_of(input logic [3:0] s);
    case (s)
      S_PRE1, S_PRE2:       gap_of = T_RP;
      S_EMR, S_MRD, S_MR:   gap_of = T_MRD;
      S_REF1, S_REF2:       gap_of = T_RFC;
      default:              gap_of = 0;
    endcase
  endfunction

  function automatic logic [3:0] next_of(input logic [3:0] s);
    case (s)
      S_PRE1:  next_of = S_EMR;
      S_EMR:   next_of = S_MRD;
      S_MRD:   next_of = S_PRE2;
      S_PRE2:  next_of = S_REF1;
      S_REF1:  next_of = S_REF2;
      S_REF2:  next_of = S_MR;
      default: next_of = S_DLLW;
    endcase
  endfunction

  assign w_dll_met = int'(r_dll) >= DLL_WAIT;
  assign w_wrap    = (r_state == S_DONE) && (int'(r_tmr) == REFRESH_INTERVAL - 1);

  // Next-state decode: command cycle, then gap NOPs, then the following state.
  always_comb begin
    w_nstate = r_state;
    w_nissue = 1'b0;
    w_ngap   = r_gap;
    w_nwait  = r_wait;
    case (r_state)
      S_WAIT: begin
        if (int'(r_wait) >= WAIT_POWERUP) w_nstate = S_CKE;
        else                              w_nwait  = r_wait + WAIT_W'(1);
      end
      S_CKE: begin
        w_nstate = S_PRE1;
        w_nissue = 1'b1;
      end
      S_DLLW: if (w_dll_met) w_nstate = S_DONE;
      S_DONE: ;
      default: begin
        if (r_issue && gap_of(r_state) != 0) begin
          w_ngap = GAP_W'(gap_of(r_state) - 1);
        end else if (r_issue || r_gap == '0) begin
          w_nstate = next_of(r_state);
          w_nissue = (w_nstate != S_DLLW);
          // DLL wait already satisfied: skip DLLW entirely
          if (w_nstate == S_DLLW && w_dll_met) w_nstate = S_DONE;
        end else begin
          w_ngap = r_gap - GAP_W'(1);
        end
      end
    endcase
  end

  // Bus values for the state being entered.
  always_comb begin
    w_cke  = (w_nstate != S_WAIT);
    w_done = (w_nstate == S_DONE);
    w_cmd  = C_NOP;
    w_ba   = 2'b00;
    w_addr = 13'h0000;
    if (w_nissue) begin
      case (w_nstate)
        S_PRE1, S_PRE2: begin w_cmd = C_PRE; w_addr = 13'h0400; end
        S_EMR:          begin w_cmd = C_LMR; w_ba = 2'b01; w_addr = EXT_MODE_REG; end
        S_MRD:          begin w_cmd = C_LMR; w_addr = MODE_REG | 13'h0100; end
        S_REF1, S_REF2: w_cmd = C_REF;
        S_MR:           begin w_cmd = C_LMR; w_addr = MODE_REG; end
        default:        ;
      endcase
    end
  end

  // Sequencer state, timers and registered outputs; clock loss behaves like reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT; r_issue <= 1'b0; r_gap <= '0; r_wait <= '0;
      r_dll   <= '0;     r_tmr   <= '0;
      r_cke   <= 1'b0;   r_cs_n  <= 1'b0; r_cmd <= C_NOP; r_ba <= 2'b00;
      r_addr  <= '0;     r_done  <= 1'b0; r_req <= 1'b0;  r_ovr <= 1'b0;
    end else if (!ddr_clk_ok) begin
      r_state <= S_WAIT; r_issue <= 1'b0; r_gap <= '0; r_wait <= '0;
      r_dll   <= '0;     r_tmr   <= '0;
      r_cke   <= 1'b0;   r_cs_n  <= 1'b0; r_cmd <= C_NOP; r_ba <= 2'b00;
      r_addr  <= '0;     r_done  <= 1'b0; r_req <= 1'b0;  r_ovr <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_issue <= w_nissue;
      r_gap   <= w_ngap;
      r_wait  <= w_nwait;
      r_cke   <= w_cke;
      r_cs_n  <= 1'b0;
      r_cmd   <= w_cmd;
      r_ba    <= w_ba;
      r_addr  <= w_addr;
      r_done  <= w_done;
      if (w_nstate == S_MRD && r_state != S_MRD) r_dll <= DLL_W'(1);
      else if (!w_dll_met)                       r_dll <= r_dll + DLL_W'(1);
      if (r_state == S_DONE) begin
        r_tmr <= w_wrap ? '0 : r_tmr + RI_W'(1);
        if (w_wrap) begin
          r_req <= 1'b1;                 // a fresh request beats a same-cycle ack
          if (r_req) r_ovr <= 1'b1;
        end else if (refresh_ack && r_req) begin
          r_req <= 1'b0;
        end
      end
    end
  end

  assign cke             = r_cke;
  assign cs_n            = r_cs_n;
  assign cmd             = r_cmd;
  assign ba              = r_ba;
  assign addr            = r_addr;
  assign done            = r_done;
  assign refresh_req     = r_req;
  assign refresh_overrun = r_ovr;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Bench for ddr_init_seq: two instances (DLL wait 10 and 30) share stimulus.
// Expected bus words are pushed per cycle into a scoreboard queue and popped
// after each clock edge.
module tb_ddr_init_seq;
  logic gclk = 1'b0;
  logic reset, ok, ack;

  logic        cke_a, csn_a, done_a, req_a, ovr_a;
  logic [2:0]  cmd_a;
  logic [1:0]  ba_a;
  logic [12:0] addr_a;
  logic        cke_b, csn_b, done_b, req_b, ovr_b;
  logic [2:0]  cmd_b;
  logic [1:0]  ba_b;
  logic [12:0] addr_b;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { int cyc; logic [22:0] a; logic [22:0] b; } exp_t;
  exp_t sb[$];

  localparam logic [22:0] RST_VEC = {1'b0, 1'b0, 3'b111, 2'b00, 13'h0, 3'b000};

  always #5 gclk = ~gclk;

  ddr_init_seq #(.WAIT_POWERUP(20), .T_RP(2), .T_MRD(2), .T_RFC(4),
                 .DLL_WAIT(10), .REFRESH_INTERVAL(16)) dut_a (
    .clk(gclk), .reset(reset), .ddr_clk_ok(ok), .cke(cke_a), .cs_n(csn_a),
    .cmd(cmd_a), .ba(ba_a), .addr(addr_a), .done(done_a),
    .refresh_req(req_a), .refresh_ack(ack), .refresh_overrun(ovr_a));

  ddr_init_seq #(.WAIT_POWERUP(20), .T_RP(2), .T_MRD(2), .T_RFC(4),
                 .DLL_WAIT(30), .REFRESH_INTERVAL(16)) dut_b (
    .clk(gclk), .reset(reset), .ddr_clk_ok(ok), .cke(cke_b), .cs_n(csn_b),
    .cmd(cmd_b), .ba(ba_b), .addr(addr_b), .done(done_b),
    .refresh_req(req_b), .refresh_ack(ack), .refresh_overrun(ovr_b));

  wire [22:0] got_a = {cke_a, csn_a, cmd_a, ba_a, addr_a, done_a, req_a, ovr_a};
  wire [22:0] got_b = {cke_b, csn_b, cmd_b, ba_b, addr_b, done_b, req_b, ovr_b};

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Init timeline with W=20, RP=2, MRD=2, RFC=4 taken from the sequence table.
  function automatic logic [22:0] exp_vec(input int c, input int dc, input bit rq, input bit ov);
    logic [2:0]  cm = 3'b111;
    logic [1:0]  b  = 2'b00;
    logic [12:0] ad = 13'h0;
    case (c)
      21, 30: begin cm = 3'b010; ad = 13'h0400; end
      24:     begin cm = 3'b000; b = 2'b01; ad = 13'h0000; end
      27:     begin cm = 3'b000; ad = 13'h0121; end
      33, 38: cm = 3'b001;
      43:     begin cm = 3'b000; ad = 13'h0021; end
      default: ;
    endcase
    return {(c >= 20), 1'b0, cm, b, ad, (c >= dc), rq, ov};
  endfunction

  // Acks are sampled at edges 65, 110 and 111 when refr is set.
  task automatic run_seg(input string nm, input int n, input bit refr);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e.cyc = c;
      e.a = exp_vec(c, 46, refr && ((c >= 62 && c < 65) || (c >= 78 && c < 111)),
                    refr && (c >= 94));
      e.b = exp_vec(c, 57, refr && (c >= 73 && c < 110), refr && (c >= 89));
      sb.push_back(e);
    end
    for (int c = 0; c < n; c++) begin
      ack = refr && (c == 65 || c == 110 || c == 111);
      @(posedge gclk); #1;
      e = sb.pop_front();
      chk($sformatf("%s_a@%0d", nm, e.cyc), got_a, e.a);
      chk($sformatf("%s_b@%0d", nm, e.cyc), got_b, e.b);
    end
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ok = 1'b1; ack = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    chk("rst_a", got_a, RST_VEC);
    chk("rst_b", got_b, RST_VEC);
    reset = 1'b0;

    // Full init, refresh request/ack, overrun and ack-vs-wrap collision
    run_seg("init", 116, 1'b1);

    // Clock loss from DONE clears outputs, timer and sticky overrun
    ok = 1'b0;
    @(posedge gclk); #1;
    chk("loss_a", got_a, RST_VEC);
    chk("loss_b", got_b, RST_VEC);
    ok = 1'b1;

    // Restart, then lose the clock at cycle 35 (inside REF1 gap)
    run_seg("r1", 35, 1'b0);
    ok = 1'b0;
    @(posedge gclk); #1;
    chk("loss35_a", got_a, RST_VEC);
    chk("loss35_b", got_b, RST_VEC);
    ok = 1'b1;

    // Restart again, then assert reset between edges mid-REF1
    run_seg("r2", 36, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_a", got_a, RST_VEC);
    chk("arst_b", got_b, RST_VEC);
    #10 reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
